mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_if.sv | 17 +
 rtl/mdu.sv | 148 ++++++++++++++
 tb/tb_mdu.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Bundles the MDU operation request and its result/status signals.
// master = issuing pipeline stage, slave = the MDU.
interface mdu_if;
    logic [3:0]  MDop;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDout;

    // start is a single-cycle valid for a long op; !busy is its ready, so an
    // op is accepted exactly in a cycle where start is high.
    modport master (output MDop, A, B, input start, busy, HI, LO, MDout);
    modport slave  (input MDop, A, B, output start, busy, HI, LO, MDout);
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO, a fixed-latency busy counter and mt/mf access.
// Optional MDU_MADD_EN adds madd/maddu (HI:LO accumulate).
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic clk,
    input logic reset,
    mdu_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10
    } md_op_e;

    md_op_e        op;
    logic [31:0]   hi_q, lo_q;
    logic [63:0]   pend_q;
    logic          pend_wr_q;
    logic [CW-1:0] count_q;
    logic          busy;
    logic          mt_window;

    logic [63:0]   prod_s, prod_u;
    logic [31:0]   quo_s, rem_s, quo_u, rem_u;
    logic          div_ovf;

    logic          op_start;
    logic          op_write;
    logic [63:0]   op_result;
    logic [CW-1:0] op_load;

    assign op   = md_op_e'(bus.MDop);
    assign busy = (count_q != '0);
    // mthi/mtlo are still accepted on the final busy cycle so they land after the pending write.
    assign mt_window = (count_q <= ONE);

    assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    assign quo_s  = $signed(bus.A) / $signed(bus.B);
    assign rem_s  = $signed(bus.A) % $signed(bus.B);
    assign quo_u  = bus.A / bus.B;
    assign rem_u  = bus.A % bus.B;
    assign div_ovf = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);

`ifdef MDU_MADD_EN
    logic [63:0] hi_lo;
    assign hi_lo = {hi_q, lo_q};
`endif

    always_comb begin
        op_start  = 1'b0;
        op_write  = 1'b1;
        op_result = 64'd0;
        op_load   = '0;
        case (op)
            OP_MULT: begin
                op_start  = 1'b1;
                op_result = prod_s;
                op_load   = MULT_LOAD;
            end
            OP_MULTU: begin
                op_start  = 1'b1;
                op_result = prod_u;
                op_load   = MULT_LOAD;
            end
            OP_DIV: begin
                op_start  = 1'b1;
                op_write  = (bus.B != 32'd0);
                op_result = div_ovf ? {32'd0, bus.A} : {rem_s, quo_s};
                op_load   = DIV_LOAD;
            end
            OP_DIVU: begin
                op_start  = 1'b1;
                op_write  = (bus.B != 32'd0);
                op_result = {rem_u, quo_u};
                op_load   = DIV_LOAD;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                op_start  = 1'b1;
                op_result = hi_lo + prod_s;
                op_load   = MULT_LOAD;
            end
            OP_MADDU: begin
                op_start  = 1'b1;
                op_result = hi_lo + prod_u;
                op_load   = MULT_LOAD;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_q    <= 64'd0;
            pend_wr_q <= 1'b0;
            count_q   <= '0;
        end else begin
            if (busy) begin
                count_q <= count_q - ONE;
                if (count_q == ONE && pend_wr_q) begin
                    hi_q <= pend_q[63:32];
                    lo_q <= pend_q[31:0];
                end
            end else if (op_start) begin
                pend_q    <= op_result;
                pend_wr_q <= op_write;
                count_q   <= op_load;
            end
            // Later assignments win, giving mthi/mtlo priority over the pending write.
            if (mt_window && op == OP_MTHI) hi_q <= bus.A;
            if (mt_window && op == OP_MTLO) lo_q <= bus.A;
        end
    end

    always_comb begin
        bus.MDout = 32'd0;
        case (op)
            OP_MFHI: bus.MDout = hi_q;
            OP_MFLO: bus.MDout = lo_q;
            default: ;
        endcase
    end

    assign bus.start = op_start && !busy;
    assign bus.busy  = busy;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Directed + random bench for mdu: fixed-latency scoreboard of {HI,LO} results.
// Build with or without +define+MDU_MADD_EN; the madd step adapts.
module tb_mdu;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam logic [3:0] NOP = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8, MADD = 4'd9;

    logic clk = 1'b0;
    logic reset;
    mdu_if bus ();

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mhi = 32'd0, mlo = 32'd0;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.MDop = op;
        bus.A    = a;
        bus.B    = b;
        #1;
    endtask

    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(op, a, b);
        chk({tag, " start"}, {63'd0, bus.start}, 64'd1);
        next_cycle();
        drive(NOP, 32'd0, 32'd0);
    endtask

    // Reference model written with native int/longint arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        int ia, ib, q, r;
        longint sa, sb;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        case (op)
            MULT:  return 64'(sa * sb);
            MULTU: return {32'd0, a} * {32'd0, b};
            DIV: begin
                if (b == 32'd0) return cur;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
                q = ia / ib;
                r = ia % ib;
                return {r, q};
            end
            DIVU:  return (b == 32'd0) ? cur : {a % b, a / b};
            default: return cur;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        logic [63:0] old, got;
        int n;
        old = {mhi, mlo};
        n = (op == DIV || op == DIVU) ? DIV_N : MULT_N;
        exp_q.push_back(exp);
        issue(tag, op, a, b);
        for (int k = 1; k <= n; k++) begin
            chk({tag, " busy"}, {63'd0, bus.busy}, 64'd1);
            if (k == n) chk({tag, " hilo_old"}, {bus.HI, bus.LO}, old);
            next_cycle();
        end
        chk({tag, " busy_end"}, {63'd0, bus.busy}, 64'd0);
        got = exp_q.pop_front();
        chk({tag, " hilo"}, {bus.HI, bus.LO}, got);
        {mhi, mlo} = got;
    endtask

    initial begin
        logic [3:0] rop;
        logic [31:0] ra, rb;

        reset = 1'b1;
        drive(NOP, 32'd0, 32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        chk("reset busy", {63'd0, bus.busy}, 64'd0);
        chk("reset hilo", {bus.HI, bus.LO}, 64'd0);
        chk("reset mdout", {32'd0, bus.MDout}, 64'd0);

        drive(4'd15, 32'd1, 32'd1);
        chk("undefined op start", {63'd0, bus.start}, 64'd0);
        drive(MFHI, 32'd0, 32'd0);
        chk("mfhi start", {63'd0, bus.start}, 64'd0);

        run_op("mult neg", MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("div neg", DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu by0", DIVU, 32'd7, 32'd0, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("div by0", DIV, 32'd9, 32'd0, 64'h0000_0000_8000_0000);

        drive(MTHI, 32'h1234_5678, 32'd0);
        chk("mthi start", {63'd0, bus.start}, 64'd0);
        next_cycle();
        drive(MFHI, 32'd0, 32'd0);
        chk("mfhi mdout", {32'd0, bus.MDout}, 64'h1234_5678);
        chk("mthi busy", {63'd0, bus.busy}, 64'd0);
        drive(MFLO, 32'd0, 32'd0);
        chk("mflo mdout", {32'd0, bus.MDout}, 64'h8000_0000);
        mhi = 32'h1234_5678;

        // mtlo and a second mult during busy must be ignored.
        issue("mult busy", MULT, 32'd5, 32'd6);
        drive(MFHI, 32'd0, 32'd0);
        chk("mfhi while busy", {32'd0, bus.MDout}, {32'd0, mhi});
        next_cycle();
        drive(MULT, 32'd1, 32'd1);
        chk("start while busy", {63'd0, bus.start}, 64'd0);
        next_cycle();
        drive(MTLO, 32'hDEAD_BEEF, 32'd0);
        next_cycle();
        drive(NOP, 32'd0, 32'd0);
        chk("mtlo while busy", {32'd0, bus.LO}, {32'd0, mlo});
        next_cycle();
        next_cycle();
        chk("mult busy result", {bus.HI, bus.LO}, 64'd30);
        {mhi, mlo} = 64'd30;

        // mthi on the final busy cycle overrides the pending HI only.
        issue("mult then mthi", MULT, 32'd3, 32'd4);
        for (int k = 0; k < MULT_N - 1; k++) next_cycle();
        drive(MTHI, 32'hABCD_0000, 32'd0);
        next_cycle();
        drive(NOP, 32'd0, 32'd0);
        chk("mthi on final edge", {bus.HI, bus.LO}, 64'hABCD_0000_0000_000C);
        chk("mthi final busy", {63'd0, bus.busy}, 64'd0);
        {mhi, mlo} = 64'hABCD_0000_0000_000C;

        for (int i = 0; i < 6; i++) begin
            rop = 4'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : ((rop >= DIV) ? 32'($urandom_range(1, 300)) - 32'd150 : $urandom);
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, model(rop, ra, rb, {mhi, mlo}));
        end

        drive(MTHI, 32'd0, 32'd0);
        next_cycle();
        drive(MTLO, 32'hFFFF_FFFF, 32'd0);
        next_cycle();
        {mhi, mlo} = 64'h0000_0000_FFFF_FFFF;
`ifdef MDU_MADD_EN
        run_op("madd carry", MADD, 32'd1, 32'd1, 64'h0000_0001_0000_0000);
`else
        drive(MADD, 32'd1, 32'd1);
        chk("madd disabled start", {63'd0, bus.start}, 64'd0);
        next_cycle();
        drive(NOP, 32'd0, 32'd0);
        chk("madd disabled busy", {63'd0, bus.busy}, 64'd0);
        for (int k = 0; k < MULT_N; k++) next_cycle();
        chk("madd disabled hilo", {bus.HI, bus.LO}, {mhi, mlo});
`endif

        // Reset in the third busy cycle aborts the op; a concurrent mthi is overridden too.
        issue("mult reset", MULT, 32'd7, 32'd9);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        drive(MTHI, 32'h5555_5555, 32'd0);
        next_cycle();
        reset = 1'b0;
        drive(NOP, 32'd0, 32'd0);
        chk("abort busy", {63'd0, bus.busy}, 64'd0);
        chk("abort hilo", {bus.HI, bus.LO}, 64'd0);
        for (int k = 0; k < MULT_N + 1; k++) next_cycle();
        chk("abort busy later", {63'd0, bus.busy}, 64'd0);
        chk("abort hilo later", {bus.HI, bus.LO}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
